// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-bus access unit. Runs the IDLE/REQ/WAIT/DONE
// handshake, builds byte strobes, replicates store data, aligns and extends
// load data, detects misaligned addresses and counts stall cycles.
// Optional feature macro: MEM_UNALIGNED_LR_EN adds LWL/LWR/SWL/SWR support.

package mem_access_unit_pkg;
  localparam logic [1:0] MSIZE4 = 2'b00;
  localparam logic [1:0] MSIZE2 = 2'b01;
  localparam logic [1:0] MSIZE1 = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rt_old,
  input  dbus_resp_t       resp,
  output dbus_req_t        req,
  output logic             stall,
  output logic             out_valid,
  output logic [31:0]      rdata,
  output logic             adel,
  output logic             ades,
  output logic [31:0]      badvaddr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_LWL   = 3'b011;
  localparam logic [2:0] OP_LWR   = 3'b100;
  localparam logic [2:0] OP_SWL   = 3'b101;
  localparam logic [2:0] OP_SWR   = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              kill_q, kill_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              sign_q, sign_d;
  logic [3:0]        strobe_q, strobe_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              is_load, is_store, is_lr, op_active;
  logic              align_ok, addr_err, accept;
  logic [1:0]        n;
  logic [31:0]       cap_addr, cap_data;
  logic [1:0]        cap_size;
  logic [3:0]        cap_strobe;
  logic [31:0]       shifted, load_res;

`ifdef MEM_UNALIGNED_LR_EN
  logic [2:0]        op_q, op_d;
  logic [31:0]       rt_old_q, rt_old_d;
  logic [31:0]       lr_mask;
`else
  logic              unused_rt_old;
  assign unused_rt_old = ^rt_old;
`endif

  assign n = addr[1:0];

  // Decode, alignment check, address-error and stall outputs
  always_comb begin
    is_load  = (op == OP_LOAD);
    is_store = (op == OP_STORE);
    is_lr    = 1'b0;
`ifdef MEM_UNALIGNED_LR_EN
    is_lr    = (op == OP_LWL) || (op == OP_LWR) || (op == OP_SWL) || (op == OP_SWR);
`endif
    op_active = is_load | is_store | is_lr;
    case (size)
      MSIZE2:  align_ok = ~addr[0];
      MSIZE1:  align_ok = 1'b1;
      default: align_ok = (addr[1:0] == 2'b00);
    endcase
    addr_err = CHECK_ALIGN & in_valid & (is_load | is_store) & ~align_ok;
    adel     = addr_err & is_load;
    ades     = addr_err & is_store;
    badvaddr = addr_err ? addr : 32'h0;
    accept   = (state_q == S_IDLE) & in_valid & op_active & ~flush & ~addr_err;
    stall    = (in_valid & op_active & ~addr_err & (state_q != S_DONE)) |
               (state_q == S_REQ) | (state_q == S_WAIT);
  end

  // Request fields computed from the incoming instruction
  always_comb begin
    cap_addr = addr;
    cap_size = size;
    case (size)
      MSIZE1: begin
        cap_strobe = 4'(4'b0001 << n);
        cap_data   = {4{wdata[7:0]}};
      end
      MSIZE2: begin
        cap_strobe = 4'(4'b0011 << n);
        cap_data   = {2{wdata[15:0]}};
      end
      default: begin
        cap_strobe = 4'b1111;
        cap_data   = wdata;
      end
    endcase
`ifdef MEM_UNALIGNED_LR_EN
    if (is_lr) begin
      cap_addr   = {addr[31:2], 2'b00};
      cap_size   = MSIZE4;
      cap_strobe = 4'b1111;
      cap_data   = wdata;
      if (op == OP_SWL) begin
        cap_strobe = 4'(4'b1111 >> (2'(2'd3 - n)));
        cap_data   = wdata >> {2'(2'd3 - n), 3'b000};
      end else if (op == OP_SWR) begin
        cap_strobe = 4'(4'b1111 << n);
        cap_data   = wdata << {n, 3'b000};
      end
    end
`endif
  end

  // Load alignment, extension and LWL/LWR merge of the returned bus word
  always_comb begin
    shifted = resp.data >> {off_q, 3'b000};
    case (size_q)
      MSIZE1:  load_res = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      MSIZE2:  load_res = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_res = shifted;
    endcase
`ifdef MEM_UNALIGNED_LR_EN
    lr_mask = 32'h0;
    if (op_q == OP_LWL) begin
      lr_mask  = 32'hFFFF_FFFF << {2'(2'd3 - off_q), 3'b000};
      load_res = ((resp.data << {2'(2'd3 - off_q), 3'b000}) & lr_mask) | (rt_old_q & ~lr_mask);
    end else if (op_q == OP_LWR) begin
      lr_mask  = 32'hFFFF_FFFF >> {off_q, 3'b000};
      load_res = (shifted & lr_mask) | (rt_old_q & ~lr_mask);
    end
`endif
  end

  // Next-state, kill tracking, capture, completion and stall counter
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    out_valid_d = 1'b0;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    size_d      = size_q;
    off_d       = off_q;
    sign_d      = sign_q;
    strobe_d    = strobe_q;
    wdata_d     = wdata_q;
`ifdef MEM_UNALIGNED_LR_EN
    op_d        = op_q;
    rt_old_d    = rt_old_q;
`endif
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          state_d  = S_REQ;
          addr_d   = cap_addr;
          size_d   = cap_size;
          off_d    = n;
          sign_d   = sign_ext;
          strobe_d = cap_strobe;
          wdata_d  = cap_data;
`ifdef MEM_UNALIGNED_LR_EN
          op_d     = op;
          rt_old_d = rt_old;
`endif
        end
      end
      S_REQ: begin
        if (flush) kill_d = 1'b1;
        if (resp.addr_ok) begin
          if (resp.data_ok) begin
            state_d     = S_DONE;
            rdata_d     = load_res;
            out_valid_d = ~kill_d;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (resp.data_ok) begin
          state_d     = S_DONE;
          rdata_d     = load_res;
          out_valid_d = ~kill_d;
        end
      end
      default: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    endcase
    stall_cnt_d = (stall && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      stall_cnt_q <= '0;
      addr_q      <= 32'h0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      sign_q      <= 1'b0;
      strobe_q    <= 4'b0000;
      wdata_q     <= 32'h0;
`ifdef MEM_UNALIGNED_LR_EN
      op_q        <= 3'b000;
      rt_old_q    <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      rdata_q     <= rdata_d;
      stall_cnt_q <= stall_cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sign_q      <= sign_d;
      strobe_q    <= strobe_d;
      wdata_q     <= wdata_d;
`ifdef MEM_UNALIGNED_LR_EN
      op_q        <= op_d;
      rt_old_q    <= rt_old_d;
`endif
    end
  end

  // Bus request driven from captured registers; valid only in REQ
  always_comb begin
    req        = '0;
    req.valid  = (state_q == S_REQ);
    req.addr   = addr_q;
    req.size   = size_q;
    req.strobe = strobe_q;
    req.data   = wdata_q;
  end

  assign out_valid = out_valid_q;
  assign rdata     = rdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; LR tests active with MEM_UNALIGNED_LR_EN.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid, flush, sign_ext;
  logic [2:0]          op;
  logic [1:0]          size;
  logic [31:0]         addr, wdata, rt_old;
  dbus_resp_t          resp;
  dbus_req_t           req;
  logic                stall, out_valid, adel, ades;
  logic [31:0]         rdata, badvaddr;
  logic [TB_CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.CNT_W(TB_CNT_W), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush), .op(op),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rt_old(rt_old),
    .resp(resp), .req(req), .stall(stall), .out_valid(out_valid), .rdata(rdata),
    .adel(adel), .ades(ades), .badvaddr(badvaddr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; sign_ext = 1'b0; op = 3'b000; size = 2'b00;
    addr = 32'h0; wdata = 32'h0; rt_old = 32'h0; resp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one transaction; addr_ok held low for addr_wait REQ cycles, then addr_ok&data_ok.
  task automatic run_txn(input logic [2:0] t_op, input logic [1:0] t_size, input logic t_sign,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [31:0] t_rt, input logic [31:0] t_rsp, input int addr_wait,
                         output dbus_req_t req_seen, output logic stable,
                         output logic [31:0] rd, output logic ov,
                         output logic [TB_CNT_W-1:0] cnt_req, output logic [TB_CNT_W-1:0] cnt_done);
    @(negedge clk);
    in_valid = 1'b1; op = t_op; size = t_size; sign_ext = t_sign;
    addr = t_addr; wdata = t_wdata; rt_old = t_rt; resp = '0;
    @(negedge clk);
    req_seen = req; cnt_req = stall_cnt; stable = 1'b1;
    for (int i = 0; i < addr_wait; i++) begin
      @(negedge clk);
      if (req !== req_seen) stable = 1'b0;
    end
    resp.addr_ok = 1'b1; resp.data_ok = 1'b1; resp.data = t_rsp;
    @(negedge clk);
    rd = rdata; ov = out_valid; cnt_done = stall_cnt;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (req.valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b expected 0", req.valid); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_load_word();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; op = 3'b001; size = 2'b00; addr = 32'h100;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lw_accept_stall: got %b expected 1", stall); end
    @(negedge clk);
    n_cmp++; if (req.valid !== 1'b1 || req.addr !== 32'h100 || req.strobe !== 4'b1111)
      begin n_bad++; $display("FAIL lw_req: got v=%b a=%h s=%b expected v=1 a=00000100 s=1111", req.valid, req.addr, req.strobe); end
    resp.addr_ok = 1'b1; resp.data_ok = 1'b1; resp.data = 32'h8000_00F0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lw_out_valid: got %b expected 1", out_valid); end
    n_cmp++; if (rdata !== 32'h8000_00F0) begin n_bad++; $display("FAIL lw_rdata: got %h expected 800000f0", rdata); end
    n_cmp++; if (req.valid !== 1'b0) begin n_bad++; $display("FAIL lw_done_req_valid: got %b expected 0", req.valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lw_done_stall: got %b expected 0", stall); end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lw_pulse_width: got %b expected 0", out_valid); end
  endtask

  task automatic test_load_ext();
    dbus_req_t rq; logic st, ov; logic [31:0] rd; logic [TB_CNT_W-1:0] c0, c1;
    do_reset();
    run_txn(3'b001, 2'b10, 1'b1, 32'h103, 32'h0, 32'h0, 32'h8012_3456, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_signed: got %h expected ffffff80", rd); end
    run_txn(3'b001, 2'b10, 1'b0, 32'h103, 32'h0, 32'h0, 32'h8012_3456, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rd !== 32'h0000_0080) begin n_bad++; $display("FAIL lb_unsigned: got %h expected 00000080", rd); end
    run_txn(3'b001, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 32'h9ABC_1234, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rd !== 32'h0000_0012) begin n_bad++; $display("FAIL lb_lane1: got %h expected 00000012", rd); end
    run_txn(3'b001, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0, 32'h9ABC_1234, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rd !== 32'hFFFF_9ABC) begin n_bad++; $display("FAIL lh_signed: got %h expected ffff9abc", rd); end
    n_cmp++; if (rq.strobe !== 4'b1100) begin n_bad++; $display("FAIL lh_strobe: got %b expected 1100", rq.strobe); end
    run_txn(3'b001, 2'b01, 1'b1, 32'h100, 32'h0, 32'h0, 32'h0000_7FFF, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rd !== 32'h0000_7FFF) begin n_bad++; $display("FAIL lh_positive: got %h expected 00007fff", rd); end
  endtask

  task automatic test_store();
    dbus_req_t rq; logic st, ov; logic [31:0] rd; logic [TB_CNT_W-1:0] c0, c1;
    do_reset();
    run_txn(3'b010, 2'b01, 1'b0, 32'h102, 32'h0000_1234, 32'h0, 32'h0, 3, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rq.strobe !== 4'b1100 || rq.data !== 32'h1234_1234 || rq.addr !== 32'h102)
      begin n_bad++; $display("FAIL sh_req: got s=%b d=%h a=%h expected s=1100 d=12341234 a=00000102", rq.strobe, rq.data, rq.addr); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL sh_stable: got %b expected 1", st); end
    n_cmp++; if (c1 - c0 !== TB_CNT_W'(4)) begin n_bad++; $display("FAIL sh_stall_delta: got %0d expected 4", c1 - c0); end
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL sh_out_valid: got %b expected 1", ov); end
    run_txn(3'b010, 2'b10, 1'b0, 32'h101, 32'h0000_00AB, 32'h0, 32'h0, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rq.strobe !== 4'b0010 || rq.data !== 32'hABAB_ABAB)
      begin n_bad++; $display("FAIL sb_req: got s=%b d=%h expected s=0010 d=abababab", rq.strobe, rq.data); end
  endtask

  task automatic test_addr_error();
    logic [TB_CNT_W-1:0] c0;
    do_reset();
    @(negedge clk);
    c0 = stall_cnt;
    in_valid = 1'b1; op = 3'b001; size = 2'b00; addr = 32'h101;
    #1;
    n_cmp++; if (adel !== 1'b1 || ades !== 1'b0) begin n_bad++; $display("FAIL lw_adel: got adel=%b ades=%b expected 1 0", adel, ades); end
    n_cmp++; if (badvaddr !== 32'h101) begin n_bad++; $display("FAIL lw_badvaddr: got %h expected 00000101", badvaddr); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lw_err_stall: got %b expected 0", stall); end
    @(negedge clk);
    n_cmp++; if (req.valid !== 1'b0) begin n_bad++; $display("FAIL lw_err_req: got %b expected 0", req.valid); end
    n_cmp++; if (stall_cnt !== c0) begin n_bad++; $display("FAIL lw_err_cnt: got %h expected %h", stall_cnt, c0); end
    op = 3'b010; size = 2'b01; addr = 32'h103;
    #1;
    n_cmp++; if (ades !== 1'b1 || adel !== 1'b0) begin n_bad++; $display("FAIL sh_ades: got ades=%b adel=%b expected 1 0", ades, adel); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; op = 3'b001; size = 2'b00; addr = 32'h40; flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (req.valid !== 1'b0) begin n_bad++; $display("FAIL flush_idle_block: got %b expected 0", req.valid); end
    flush = 1'b0;
    @(negedge clk);
    resp.addr_ok = 1'b1;
    @(negedge clk);
    resp = '0;
    n_cmp++; if (req.valid !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL wait_state: got v=%b stall=%b expected 0 1", req.valid, stall); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    resp.data_ok = 1'b1; resp.data = 32'h5555_AAAA;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_wait_ov: got %b expected 0", out_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_done_stall: got %b expected 0", stall); end
    idle_inputs();
    @(negedge clk);
    resp.data_ok = 1'b1; resp.data = 32'h1111_2222;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || req.valid !== 1'b0 || rdata !== 32'h5555_AAAA)
      begin n_bad++; $display("FAIL idle_data_ok: got ov=%b v=%b rd=%h expected 0 0 5555aaaa", out_valid, req.valid, rdata); end
    resp = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; op = 3'b001; size = 2'b00; addr = 32'h80;
    @(negedge clk);
    resp.addr_ok = 1'b1;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    n_cmp++; if (req.valid !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL reset_wait: got v=%b stall=%b expected 0 0", req.valid, stall); end
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_wait_cnt: got %h expected 0", stall_cnt); end
    @(negedge clk);
    reset = 1'b0;
    resp.data_ok = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wait_ov: got %b expected 0", out_valid); end
    resp = '0;
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; op = 3'b001; size = 2'b00; addr = 32'h0;
    repeat (20) @(negedge clk);
    n_cmp++; if (stall_cnt !== 4'hF) begin n_bad++; $display("FAIL stall_cnt_sat: got %h expected f", stall_cnt); end
    resp.addr_ok = 1'b1; resp.data_ok = 1'b1;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_lr();
    dbus_req_t rq; logic st, ov; logic [31:0] rd; logic [TB_CNT_W-1:0] c0, c1;
    do_reset();
`ifdef MEM_UNALIGNED_LR_EN
    run_txn(3'b110, 2'b00, 1'b0, 32'h201, 32'hAABB_CCDD, 32'h0, 32'h0, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rq.strobe !== 4'b1110 || rq.data !== 32'hBBCC_DD00 || rq.addr !== 32'h200)
      begin n_bad++; $display("FAIL swr_req: got s=%b d=%h a=%h expected 1110 bbccdd00 00000200", rq.strobe, rq.data, rq.addr); end
    run_txn(3'b101, 2'b00, 1'b0, 32'h201, 32'hAABB_CCDD, 32'h0, 32'h0, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rq.strobe !== 4'b0011 || rq.data !== 32'h0000_AABB)
      begin n_bad++; $display("FAIL swl_req: got s=%b d=%h expected 0011 0000aabb", rq.strobe, rq.data); end
    run_txn(3'b011, 2'b00, 1'b0, 32'h201, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rd !== 32'h3344_CCDD) begin n_bad++; $display("FAIL lwl_merge: got %h expected 3344ccdd", rd); end
    run_txn(3'b100, 2'b00, 1'b0, 32'h201, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, rq, st, rd, ov, c0, c1);
    n_cmp++; if (rd !== 32'hAA11_2233) begin n_bad++; $display("FAIL lwr_merge: got %h expected aa112233", rd); end
    @(negedge clk);
    in_valid = 1'b1; op = 3'b011; size = 2'b00; addr = 32'h203;
    #1;
    n_cmp++; if (adel !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL lwl_no_adel: got adel=%b stall=%b expected 0 1", adel, stall); end
    resp.addr_ok = 1'b1; resp.data_ok = 1'b1;
    repeat (3) @(negedge clk);
    idle_inputs();
    @(negedge clk);
`else
    @(negedge clk);
    in_valid = 1'b1; op = 3'b110; size = 2'b00; addr = 32'h201;
    #1;
    n_cmp++; if (stall !== 1'b0 || ades !== 1'b0) begin n_bad++; $display("FAIL lr_off_stall: got stall=%b ades=%b expected 0 0", stall, ades); end
    @(negedge clk);
    n_cmp++; if (req.valid !== 1'b0) begin n_bad++; $display("FAIL lr_off_req: got %b expected 0", req.valid); end
    idle_inputs();
`endif
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_addr_error();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_lr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the stall-cycle performance counter.
REQ-002 Parameter CHECK_ALIGN, default 1, SHALL enable address-error detection; 0 disables adel/ades.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  MEM-stage instruction present.
REQ-006 flush  in  1  kill current instruction; exception or redirect.
REQ-007 op  in  3  000 none, 001 load, 010 store, 011 LWL, 100 LWR, 101 SWL, 110 SWR.
REQ-008 size  in  2  00 word, 01 half, 10 byte; ignored for 011-110.
REQ-009 sign_ext  in  1  sign-extend sub-word loads.
REQ-010 addr, wdata, rt_old  in  32 each  effective address, store data, old rt for LWL/LWR merge.
REQ-011 resp  in  dbus_resp_t  addr_ok, data_ok, data.
REQ-012 req  out  dbus_req_t  valid, addr, size, strobe, data.
REQ-013 stall  out  1  freeze upstream pipeline.
REQ-014 out_valid  out  1  one-cycle completion pulse.
REQ-015 rdata  out  32  aligned, extended or merged load result.
REQ-016 adel, ades  out  1 each  load or store address error.
REQ-017 badvaddr  out  32  faulting address.
REQ-018 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-020 IDLE->REQ SHALL occur when in_valid & op!=000 & ~flush & no address error; addr/op/size/strobe/data/rt_old SHALL be captured.
REQ-021 req.valid SHALL be 1 only in REQ, with all req fields stable until addr_ok.
REQ-022 Transitions: REQ->WAIT on addr_ok & ~data_ok; REQ->DONE on addr_ok & data_ok; WAIT->DONE on data_ok; DONE->IDLE unconditionally.
REQ-023 Minimum latency SHALL be 2 cycles from accept to out_valid, which is 1 in DONE unless killed.
REQ-024 resp.data SHALL be registered on data_ok; rdata SHALL be valid during DONE.
REQ-025 stall SHALL be 1 when (in_valid & op!=000 & no error & state!=DONE) or state in {REQ, WAIT}.
REQ-026 Strobes: word 1111 needs addr[1:0]=00; half 0011<<addr[1:0] needs addr[0]=0; byte 0001<<addr[1:0]; sub-word store data SHALL be replicated across lanes.
REQ-027 Address errors SHALL be combinational and set adel (load class) or ades (store class) with badvaddr=addr; no request SHALL issue and stall SHALL be 0.
REQ-028 Load extension SHALL shift data right by 8*addr[1:0], then sign- or zero-extend per sign_ext.
REQ-029 flush in REQ/WAIT SHALL set a kill flag; the bus transaction SHALL complete and out_valid SHALL be suppressed.
REQ-030 flush in IDLE SHALL block issue.
REQ-031 stall_cnt SHALL increment each cycle stall=1 and hold at all-ones.
REQ-032 resp.data_ok in IDLE SHALL be ignored.

Reset
REQ-033 Reset SHALL force IDLE, clear the kill flag, stall_cnt, rdata, out_valid and req.valid, with all other outputs 0, asynchronously.
REQ-034 Reset mid-transaction SHALL drop the request with no completion pulse.

Configuration
REQ-035 With MEM_UNALIGNED_LR_EN defined, ops 011-110 SHALL be supported as follows.
REQ-036 Those ops SHALL set req.addr=addr&~3 and MSIZE4, and SHALL never raise an address error.
REQ-037 SWL SHALL use strobe 1111>>(3-n) and data wdata>>8(3-n); SWR SHALL use strobe 1111<<n and data wdata<<8n, where n=addr[1:0].
REQ-038 LWL/LWR SHALL merge the shifted memory word into rt_old byte lanes.
REQ-039 Without MEM_UNALIGNED_LR_EN, ops 011-110 SHALL be treated as op 000 and produce no request.

Verification
REQ-040 Load word at 0x100 with addr_ok&data_ok in the first REQ cycle, data 0x8000_00F0 -> out_valid in cycle 2, rdata 0x8000_00F0.
REQ-041 Signed byte load at 0x103 with data 0x80xx_xxxx -> strobe unused, rdata 0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-042 Store half at 0x102 with wdata 0x1234 -> strobe 1100, data 0x1234_1234; addr_ok held low 3 cycles -> req fields stable and stall_cnt+=4.
REQ-043 Word load at 0x101 -> adel=1, badvaddr=0x101, req.valid=0, stall=0.
REQ-044 flush during WAIT -> transaction finishes and out_valid stays 0; reset during WAIT -> IDLE and req.valid=0.
REQ-045 With MEM_UNALIGNED_LR_EN: SWR at 0x201, wdata 0xAABBCCDD -> strobe 1110, data 0xBBCCDD00, addr 0x200.
